// File: rtl/m68k_bus_pkg.sv
// m68k_bus_pkg: shared state/region types, counter width and region priority encoder
package m68k_bus_pkg;
  localparam int CNT_W = 8;
  typedef enum logic [2:0] {ST_IDLE, ST_COUNT, ST_EXT, ST_TMO, ST_ACK, ST_TERM} state_t;
  typedef enum logic [2:0] {RG_ROM, RG_RAM, RG_IO, RG_GFX, RG_DRAM, RG_CAN, RG_NONE} region_t;
  function automatic region_t pick_region(input logic rom, input logic ram, input logic io,
                                          input logic gfx, input logic dram, input logic can);
    return rom ? RG_ROM : ram ? RG_RAM : io ? RG_IO : gfx ? RG_GFX :
           dram ? RG_DRAM : can ? RG_CAN : RG_NONE;
  endfunction
endpackage

// File: rtl/m68k_wait_counter.sv
// m68k_wait_counter: loadable 8-bit up/down counter with a match flag
module m68k_wait_counter
  import m68k_bus_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  input  logic             up,
  input  logic [CNT_W-1:0] match,
  output logic             hit
);
  localparam logic [CNT_W-1:0] ONE = 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : en ? (up ? cnt_q + ONE : cnt_q - ONE) : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign hit = cnt_q == match;
endmodule

// File: rtl/m68k_dtack_generator.sv
// m68k_dtack_generator: 68000 DTACK/BERR responder with per-region wait states and timeout.
// Define M68K_DTACK_BUSERR_EN to terminate unanswered cycles with BERR instead of DTACK.
module m68k_dtack_generator
  import m68k_bus_pkg::*;
#(
  parameter int ROM_WAIT = 0,
  parameter int RAM_WAIT = 0,
  parameter int IO_WAIT  = 2,
  parameter int GFX_WAIT = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic Clk,
  input  logic Reset_H,
  input  logic AS_L,
  input  logic UDS_L,
  input  logic LDS_L,
  input  logic OnChipRomSelect_H,
  input  logic OnChipRamSelect_H,
  input  logic IOSelect_H,
  input  logic GraphicsCS_L,
  input  logic DramSelect_H,
  input  logic CanBusSelect_H,
  input  logic DramDtack_L,
  input  logic CanDtack_L,
  output logic Dtack_L,
  output logic BErr_L
);
  localparam int MAX_CNT = (1 << CNT_W) - 1;
  if (ROM_WAIT < 0 || ROM_WAIT > MAX_CNT || RAM_WAIT < 0 || RAM_WAIT > MAX_CNT ||
      IO_WAIT < 0 || IO_WAIT > MAX_CNT || GFX_WAIT < 0 || GFX_WAIT > MAX_CNT ||
      TIMEOUT < 0 || TIMEOUT > MAX_CNT) begin : g_bad_cfg
    $error("m68k_dtack_generator: wait/timeout parameter outside 0..255");
  end
  localparam logic [CNT_W-1:0] ROM_W = CNT_W'(ROM_WAIT);
  localparam logic [CNT_W-1:0] RAM_W = CNT_W'(RAM_WAIT);
  localparam logic [CNT_W-1:0] IO_W  = CNT_W'(IO_WAIT);
  localparam logic [CNT_W-1:0] GFX_W = CNT_W'(GFX_WAIT);
  localparam logic [CNT_W-1:0] TMO_W = CNT_W'(TIMEOUT);
  state_t           state_q, state_d;
  region_t          region_q, region_d, start_rg;
  logic             dtack_q, dtack_d, berr_q, berr_d;
  logic             dram_ack_q, can_ack_q;
  logic             start, launch, ext_ack, wait_done, tmo_done;
  logic [CNT_W-1:0] wait_val;
  assign start    = !AS_L && (!UDS_L || !LDS_L);
  assign launch   = state_q == ST_IDLE && start;
  assign start_rg = pick_region(OnChipRomSelect_H, OnChipRamSelect_H, IOSelect_H,
                                !GraphicsCS_L, DramSelect_H, CanBusSelect_H);
  assign wait_val = start_rg == RG_ROM ? ROM_W : start_rg == RG_RAM ? RAM_W :
                    start_rg == RG_IO ? IO_W : GFX_W;
  // external acks pass through one register, so no combinational path to Dtack_L
  assign ext_ack  = region_q == RG_DRAM ? dram_ack_q : can_ack_q;
  m68k_wait_counter u_wait (
    .clk(Clk), .rst(Reset_H), .load(launch), .load_val(wait_val),
    .en(state_q == ST_COUNT && !wait_done), .up(1'b0), .match('0), .hit(wait_done)
  );
  m68k_wait_counter u_tmo (
    .clk(Clk), .rst(Reset_H), .load(launch), .load_val('0),
    .en((state_q == ST_EXT || state_q == ST_TMO) && !tmo_done), .up(1'b1), .match(TMO_W),
    .hit(tmo_done)
  );
  always_comb begin
    state_d  = state_q;
    region_d = region_q;
    if (state_q != ST_IDLE && AS_L) state_d = ST_IDLE;
    else begin
      unique case (state_q)
        ST_IDLE: if (start) begin
          region_d = start_rg;
          state_d  = start_rg == RG_NONE ? ST_TMO :
                     (start_rg == RG_DRAM || start_rg == RG_CAN) ? ST_EXT : ST_COUNT;
        end
        ST_COUNT: state_d = wait_done ? ST_ACK : ST_COUNT;
        ST_EXT:   state_d = ext_ack ? ST_ACK : tmo_done ? ST_TERM : ST_EXT;
        ST_TMO:   state_d = tmo_done ? ST_TERM : ST_TMO;
        default:  state_d = state_q;
      endcase
    end
  end
  always_comb begin
`ifdef M68K_DTACK_BUSERR_EN
    dtack_d = state_d != ST_ACK;
    berr_d  = state_d != ST_TERM;
`else
    dtack_d = !(state_d == ST_ACK || state_d == ST_TERM);
    berr_d  = 1'b1;
`endif
  end
  always_ff @(posedge Clk) begin
    if (Reset_H) begin
      state_q    <= ST_IDLE;
      region_q   <= RG_NONE;
      dtack_q    <= 1'b1;
      berr_q     <= 1'b1;
      dram_ack_q <= 1'b0;
      can_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      region_q   <= region_d;
      dtack_q    <= dtack_d;
      berr_q     <= berr_d;
      dram_ack_q <= !DramDtack_L;
      can_ack_q  <= !CanDtack_L;
    end
  end
  assign Dtack_L = dtack_q;
  assign BErr_L  = berr_q;
endmodule

// File: tb/tb_m68k_dtack_generator.sv
// tb_m68k_dtack_generator: scenario tasks with a latency scoreboard for m68k_dtack_generator
module tb_m68k_dtack_generator;
  logic Clk = 1'b0;
  logic Reset_H, AS_L, UDS_L, LDS_L, rom, ram, io, gfx_l, dram, can, dram_ack_l, can_ack_l;
  logic Dtack_L, BErr_L;
  typedef struct {int lat; bit berr;} exp_t;
  exp_t sbq[$];
  int total = 0;
  int bad = 0;
`ifdef M68K_DTACK_BUSERR_EN
  localparam bit TERM_BERR = 1'b1;
`else
  localparam bit TERM_BERR = 1'b0;
`endif
  m68k_dtack_generator #(.ROM_WAIT(0), .RAM_WAIT(0), .IO_WAIT(2), .GFX_WAIT(4), .TIMEOUT(15)) dut (
    .Clk(Clk), .Reset_H(Reset_H), .AS_L(AS_L), .UDS_L(UDS_L), .LDS_L(LDS_L),
    .OnChipRomSelect_H(rom), .OnChipRamSelect_H(ram), .IOSelect_H(io), .GraphicsCS_L(gfx_l),
    .DramSelect_H(dram), .CanBusSelect_H(can), .DramDtack_L(dram_ack_l), .CanDtack_L(can_ack_l),
    .Dtack_L(Dtack_L), .BErr_L(BErr_L)
  );
  always #5 Clk = ~Clk;
  task automatic step;
    @(posedge Clk);
    #1;
  endtask
  task automatic idle_bus;
    AS_L = 1; UDS_L = 1; LDS_L = 1; rom = 0; ram = 0; io = 0; gfx_l = 1; dram = 0; can = 0;
    dram_ack_l = 1; can_ack_l = 1;
  endtask
  task automatic expect_resp(input int lat, input bit berr);
    sbq.push_back('{lat, berr});
  endtask
  // sel = {rom, ram, io, gfx, dram, can}; returns just after the start-sampling edge
  task automatic start(input logic [5:0] sel, input bit use_lds);
    {rom, ram, io} = sel[5:3];
    gfx_l = ~sel[2];
    {dram, can} = sel[1:0];
    AS_L = 0;
    if (use_lds) LDS_L = 0; else UDS_L = 0;
    step;
  endtask
  task automatic wait_resp(input string name);
    exp_t e;
    int n = 0;
    e = sbq.pop_front();
    while (Dtack_L && BErr_L && n < 300) begin
      step;
      n++;
    end
    total++;
    if (Dtack_L && BErr_L) begin
      bad++;
      $display("FAIL %s: no response after %0d cycles, required latency %0d", name, n, e.lat);
    end else begin
      if (n !== e.lat) begin
        bad++;
        $display("FAIL %s latency: got %0d required %0d", name, n, e.lat);
      end
      total++;
      if ({Dtack_L, BErr_L} !== (e.berr ? 2'b10 : 2'b01)) begin
        bad++;
        $display("FAIL %s outputs: got Dtack_L/BErr_L=%b required %b", name, {Dtack_L, BErr_L},
                 e.berr ? 2'b10 : 2'b01);
      end
    end
  endtask
  task automatic hold_check(input int n, input logic [1:0] req, input string name);
    for (int i = 0; i < n; i++) begin
      step;
      total++;
      if ({Dtack_L, BErr_L} !== req) begin
        bad++;
        $display("FAIL %s cycle %0d: got Dtack_L/BErr_L=%b required %b", name, i, {Dtack_L, BErr_L}, req);
      end
    end
  endtask
  task automatic release_bus(input string name);
    idle_bus;
    step;
    total++;
    if ({Dtack_L, BErr_L} !== 2'b11) begin
      bad++;
      $display("FAIL %s release: got Dtack_L/BErr_L=%b required 11", name, {Dtack_L, BErr_L});
    end
  endtask
  task automatic test_reset;
    Reset_H = 1;
    idle_bus;
    repeat (3) step;
    Reset_H = 0;
    total++;
    if ({Dtack_L, BErr_L} !== 2'b11) begin
      bad++;
      $display("FAIL reset: got Dtack_L/BErr_L=%b required 11", {Dtack_L, BErr_L});
    end
    hold_check(2, 2'b11, "reset_idle");
  endtask
  task automatic test_rom_read;
    expect_resp(1, 0);
    start(6'b100000, 0);
    wait_resp("rom_read");
    hold_check(3, 2'b01, "rom_hold");
    release_bus("rom");
  endtask
  task automatic test_strobe_required;
    AS_L = 0;
    ram = 1;
    hold_check(4, 2'b11, "no_data_strobe");
    expect_resp(1, 0);
    start(6'b010000, 1);
    wait_resp("ram_after_strobe");
    release_bus("ram");
  endtask
  task automatic test_priority;
    expect_resp(1, 0);
    start(6'b101000, 1);
    wait_resp("rom_over_io");
    release_bus("rom_over_io");
    expect_resp(3, 0);
    start(6'b001100, 1);
    wait_resp("io_over_gfx");
    release_bus("io");
    expect_resp(5, 0);
    start(6'b000110, 0);
    wait_resp("gfx_over_dram");
    release_bus("gfx");
  endtask
  task automatic test_dram;
    start(6'b000011, 0);
    for (int i = 0; i < 5; i++) begin
      can_ack_l = ~can_ack_l;
      step;
      total++;
      if (Dtack_L !== 1'b1) begin
        bad++;
        $display("FAIL dram_can_ignored cycle %0d: got Dtack_L=%b required 1", i, Dtack_L);
      end
    end
    can_ack_l = 1;
    expect_resp(2, 0);
    dram_ack_l = 0;
    wait_resp("dram_ack");
    release_bus("dram");
  endtask
  task automatic test_can;
    dram_ack_l = 0;
    start(6'b000001, 0);
    hold_check(3, 2'b11, "can_dram_ignored");
    expect_resp(2, 0);
    can_ack_l = 0;
    wait_resp("can_ack");
    release_bus("can");
  endtask
  task automatic test_timeout;
    expect_resp(16, TERM_BERR);
    start(6'b000000, 0);
    wait_resp("unmapped_timeout");
    hold_check(2, TERM_BERR ? 2'b10 : 2'b01, "term_hold");
    release_bus("unmapped");
    expect_resp(16, TERM_BERR);
    start(6'b000010, 1);
    wait_resp("dram_timeout");
    release_bus("dram_timeout");
  endtask
  task automatic test_abort;
    start(6'b000100, 0);
    hold_check(1, 2'b11, "abort_pre");
    AS_L = 1; UDS_L = 1; gfx_l = 1;
    step;
    total++;
    if ({Dtack_L, BErr_L} !== 2'b11) begin
      bad++;
      $display("FAIL abort_edge: got Dtack_L/BErr_L=%b required 11", {Dtack_L, BErr_L});
    end
    expect_resp(1, 0);
    start(6'b100000, 0);
    wait_resp("restart_after_abort");
    release_bus("restart");
    start(6'b000100, 0);
    idle_bus;
    hold_check(8, 2'b11, "abort_no_ack");
  endtask
  task automatic test_back_to_back;
    expect_resp(1, 0);
    start(6'b010000, 0);
    wait_resp("b2b_first");
    AS_L = 1; UDS_L = 1;
    step;
    total++;
    if (Dtack_L !== 1'b1) begin
      bad++;
      $display("FAIL b2b_release: got Dtack_L=%b required 1", Dtack_L);
    end
    expect_resp(3, 0);
    start(6'b001000, 0);
    wait_resp("b2b_second");
    release_bus("b2b");
  endtask
  task automatic test_reset_in_ack;
    expect_resp(1, 0);
    start(6'b100000, 0);
    wait_resp("pre_reset_ack");
    Reset_H = 1;
    idle_bus;
    step;
    total++;
    if ({Dtack_L, BErr_L} !== 2'b11) begin
      bad++;
      $display("FAIL reset_in_ack: got Dtack_L/BErr_L=%b required 11", {Dtack_L, BErr_L});
    end
    Reset_H = 0;
    expect_resp(1, 0);
    start(6'b100000, 0);
    wait_resp("after_reset_rom");
    release_bus("after_reset");
  endtask
  initial begin
    test_reset;
    test_rom_read;
    test_strobe_required;
    test_priority;
    test_dram;
    test_can;
    test_timeout;
    test_abort;
    test_back_to_back;
    test_reset_in_ack;
    total++;
    if (sbq.size() !== 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d left required 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/m68k_dtack_generator.md
# m68k_dtack_generator

Bus-cycle responder for the 68000 local bus. It takes the decoded region selects and the CPU strobes, and drives `Dtack_L` after a per-region number of wait states. Regions with their own handshake (SDRAM controller, CAN controller) have their acknowledge forwarded instead. Unmapped accesses are terminated by a bus-error timeout. It sits between the address decoder outputs and the CPU `DTACK`/`BERR` inputs.

## Interface
Parameters:
- `ROM_WAIT`, default 0: wait states for on-chip ROM.
- `RAM_WAIT`, default 0: wait states for on-chip RAM.
- `IO_WAIT`, default 2: wait states for the IO region.
- `GFX_WAIT`, default 4: wait states for the graphics region.
- `TIMEOUT`, default 255: cycles before an unanswered cycle is terminated (8-bit counter).

Ports:
- `Clk` in 1: system clock. One clock; reset is synchronous and active-high.
- `Reset_H` in 1: synchronous, active-high reset.
- `AS_L` in 1: CPU address strobe.
- `UDS_L` in 1: upper data strobe.
- `LDS_L` in 1: lower data strobe.
- `OnChipRomSelect_H` in 1: ROM region select.
- `OnChipRamSelect_H` in 1: RAM region select.
- `IOSelect_H` in 1: IO region select.
- `GraphicsCS_L` in 1: graphics region select (active low).
- `DramSelect_H` in 1: SDRAM region select.
- `CanBusSelect_H` in 1: CAN region select.
- `DramDtack_L` in 1: acknowledge from the SDRAM controller.
- `CanDtack_L` in 1: acknowledge from the CAN controller.
- `Dtack_L` out 1: registered data acknowledge to the CPU.
- `BErr_L` out 1: registered bus error to the CPU.

## Operation
- **Start condition.** A cycle starts when `AS_L`=0 and (`UDS_L`=0 or `LDS_L`=0), sampled in IDLE.
- **Region priority** (one region latched at start): ROM > RAM > IO > GFX > DRAM > CAN > none.
- **States:**
  - IDLE: start with ROM/RAM/IO/GFX → COUNT, load wait value. Start with DRAM/CAN → EXT. Start with none → TMO, counter cleared.
  - COUNT: decrement each cycle. When count = 0 → ACK.
  - EXT: when the latched region's external acknowledge samples low → ACK. The timeout counter runs in parallel; if it reaches `TIMEOUT` → TERM.
  - TMO: count up; at `TIMEOUT` → TERM.
  - ACK: `Dtack_L`=0, held until `AS_L` samples high → IDLE.
  - TERM: under `M68K_DTACK_BUSERR_EN`, `BErr_L`=0; otherwise `Dtack_L`=0. Held until `AS_L` samples high → IDLE.
- **Mid-cycle abort.** `AS_L` sampled high in any non-IDLE state → IDLE. Both outputs return high on the same edge. The cycle is abandoned and no acknowledge is issued.
- **Select changes.** Select changes after start are ignored. The region is latched at start.
- **Counter width.** The wait counter is 8 bits. Wait parameters above 255 are a configuration error and are checked by an elaboration assertion.

## Timing
- **Reset.** State IDLE, `Dtack_L`=1, `BErr_L`=1, counters 0.
- **Internal regions.** Start sampled at edge k → `Dtack_L` low after edge k+1+WAIT (WAIT=0 gives `Dtack_L` low one cycle after start).
- **External regions.** `DramDtack_L`/`CanDtack_L` low sampled at edge m → `Dtack_L` low after edge m+1. One-register latency, no combinational path.
- **Release.** `AS_L` high sampled at edge r → `Dtack_L`/`BErr_L` high after edge r.
- **Back-to-back cycles.** No new cycle is accepted in the cycle that returns to IDLE. The next start is sampled no earlier than edge r+1.
- **Timeout.** Unmapped start at edge k → termination asserted after edge k+1+`TIMEOUT`.
- **Glitch-free outputs.** Both outputs are registered; neither toggles other than as specified.

## Configuration
- `M68K_DTACK_BUSERR_EN` defined:
  - TERM drives `BErr_L`=0.
  - `Dtack_L` stays high for unmapped or timed-out cycles.
- Not defined:
  - `BErr_L` is tied to 1.
  - TERM drives `Dtack_L`=0 instead (a silent terminate), so the CPU never hangs.

## Structure
- **Package `m68k_bus_pkg`:**
  - state enum (IDLE, COUNT, EXT, TMO, ACK, TERM);
  - region enum (ROM, RAM, IO, GFX, DRAM, CAN, NONE);
  - 8-bit counter width constant.
- **Sub-module `m68k_wait_counter`:** loadable 8-bit down/up counter with a terminal flag, instantiated twice: once for wait states, once for the timeout.

## Test plan
- ROM read, `ROM_WAIT`=0: `AS_L`/`UDS_L` low at edge 10 → `Dtack_L` low after edge 11; `AS_L` high at edge 14 → `Dtack_L` high after edge 14.
- IO write, `IO_WAIT`=2, simultaneous `OnChipRomSelect_H` and `IOSelect_H`: ROM wins → `Dtack_L` low after edge k+1, not k+3.
- DRAM access: `DramDtack_L` low at edge 20 → `Dtack_L` low after edge 21; `CanDtack_L` toggling during the cycle is ignored.
- Unmapped access, `TIMEOUT`=15, with macro: `BErr_L` low after edge k+16 and `Dtack_L` stays high. Without macro: `Dtack_L` low at the same edge.
- `AS_L` raised during COUNT with `GFX_WAIT`=4 at edge k+2: no acknowledge ever, state IDLE after edge k+2. Next start accepted at edge k+3.
- `Reset_H` asserted while in ACK: `Dtack_L`=1 and `BErr_L`=1 after the next edge; state IDLE.
